// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module      : seq_pattern_gen
// Description : Bit-serial pattern transmitter. Sends PATTERN MSB-first,
//               repeated 'count' times with GAP idle cycles between repeats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_gen #(
   parameter int                 PAT_W   = 4,
   parameter logic [PAT_W-1:0]   PATTERN = 4'b1001,
   parameter int                 GAP     = 2,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             abort,
   output logic             dout,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int IW = $clog2(PAT_W);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [IW-1:0]    IDX_LAST = IW'(PAT_W - 1);
   localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAPS = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [CNT_W-1:0] rep_cnt;
   logic [GW-1:0]    gap_cnt;

   // Pattern bit at position i, counted from the MSB.
   function automatic logic pat_bit(input logic [IW-1:0] i);
      logic [PAT_W-1:0] s;
      s = PATTERN << i;
      return s[PAT_W-1];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         rep_cnt <= '0;
         gap_cnt <= '0;
         dout    <= 1'b0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (count != '0)) begin
                  state   <= SEND;
                  idx     <= '0;
                  rep_cnt <= count;
                  gap_cnt <= '0;
                  dout    <= pat_bit('0);
                  valid   <= 1'b1;
                  busy    <= 1'b1;
               end
            end

            SEND: begin
               if (abort) begin
                  state   <= IDLE;
                  idx     <= '0;
                  rep_cnt <= '0;
                  gap_cnt <= '0;
                  dout    <= 1'b0;
                  valid   <= 1'b0;
                  busy    <= 1'b0;
               end else if (idx == IDX_LAST) begin
                  idx     <= '0;
                  rep_cnt <= rep_cnt - 1'b1;
                  if (rep_cnt == REP_ONE) begin
                     state <= FIN;
                     dout  <= 1'b0;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (GAP > 0) begin
                     state   <= GAPS;
                     gap_cnt <= '0;
                     dout    <= 1'b0;
                     valid   <= 1'b0;
                  end else begin
                     dout <= pat_bit('0);
                  end
               end else begin
                  idx  <= idx + 1'b1;
                  dout <= pat_bit(idx + 1'b1);
               end
            end

            GAPS: begin
               if (abort) begin
                  state   <= IDLE;
                  idx     <= '0;
                  rep_cnt <= '0;
                  gap_cnt <= '0;
                  dout    <= 1'b0;
                  valid   <= 1'b0;
                  busy    <= 1'b0;
               end else if (gap_cnt == GAP_LAST) begin
                  state   <= SEND;
                  idx     <= '0;
                  gap_cnt <= '0;
                  dout    <= pat_bit('0);
                  valid   <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            FIN: begin
               state <= IDLE;
               done  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               dout  <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
// ============================================================================
// Module      : tb_seq_pattern_gen
// Description : Scoreboard bench for seq_pattern_gen, GAP=2 and GAP=0 builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_gen;

   localparam int          PAT_W = 4;
   localparam logic [3:0]  PAT   = 4'b1001;
   localparam int          CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] count = '0;

   logic dout2, valid2, busy2, done2;
   logic dout0, valid0, busy0, done0;

   int total = 0;
   int bad   = 0;

   // Expected words are {dout, valid, busy, done}, one per clock.
   logic [3:0] q2[$];
   logic [3:0] q0[$];
   logic [3:0] last2 = 4'b0;
   logic [3:0] last0 = 4'b0;

   always #5 clk = ~clk;

   seq_pattern_gen #(.PAT_W(PAT_W), .PATTERN(PAT), .GAP(2), .CNT_W(CNT_W)) dut2 (
      .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
      .dout(dout2), .valid(valid2), .busy(busy2), .done(done2)
   );

   seq_pattern_gen #(.PAT_W(PAT_W), .PATTERN(PAT), .GAP(0), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
      .dout(dout0), .valid(valid0), .busy(busy0), .done(done0)
   );

   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%b exp=%b (dout,valid,busy,done)", tag, $time, got, exp);
      end
   endtask

   task automatic push_xfer(input int gap, input int cnt);
      logic [3:0] w;
      for (int r = 0; r < cnt; r++) begin
         for (int b = 0; b < PAT_W; b++) begin
            w = {PAT[PAT_W-1-b], 1'b1, 1'b1, 1'b0};
            if (gap == 2) q2.push_back(w); else q0.push_back(w);
         end
         if (r < cnt - 1) begin
            for (int g = 0; g < gap; g++) begin
               if (gap == 2) q2.push_back(4'b0010); else q0.push_back(4'b0010);
            end
         end
      end
      if (gap == 2) q2.push_back(4'b0001); else q0.push_back(4'b0001);
   endtask

   // Apply the model's reaction to the inputs present at the coming edge,
   // then compare both DUTs against the next expected word.
   task automatic step();
      logic [3:0] e2, e0;
      if (rst) begin
         q2.delete();
         q0.delete();
      end else begin
         if (abort && last2[1])
            q2.delete();
         else if (start && count != '0 && q2.size() == 0 && last2 == 4'b0)
            push_xfer(2, int'(count));
         if (abort && last0[1])
            q0.delete();
         else if (start && count != '0 && q0.size() == 0 && last0 == 4'b0)
            push_xfer(0, int'(count));
      end
      @(posedge clk);
      #1;
      e2 = (q2.size() != 0) ? q2.pop_front() : 4'b0;
      e0 = (q0.size() != 0) ? q0.pop_front() : 4'b0;
      check_eq("gap2", {dout2, valid2, busy2, done2}, e2);
      check_eq("gap0", {dout0, valid0, busy0, done0}, e0);
      last2 = e2;
      last0 = e0;
   endtask

   task automatic kick(input int cnt);
      start = 1'b1;
      count = CNT_W'(cnt);
      step();
      start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q2.size() != 0 || q0.size() != 0) && n < 4000) begin
         step();
         n++;
      end
      if (q2.size() != 0 || q0.size() != 0)
         check_eq("drain_timeout", 4'b1111, 4'b0000);
      step();
   endtask

   initial begin
      // Reset held 3 cycles, then 5 idle cycles.
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (5) step();

      kick(1);
      drain();

      kick(3);
      drain();

      kick(2);
      drain();

      // count == 0 is ignored.
      kick(0);
      repeat (4) step();

      // Mid-transfer start pulses and count changes are ignored.
      kick(3);
      for (int i = 0; i < 12; i++) begin
         start = (i % 3 == 0);
         count = CNT_W'($urandom_range(1, 255));
         step();
      end
      start = 1'b0;
      drain();

      // Abort on the second bit, then a clean transfer.
      kick(2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      repeat (3) step();
      kick(2);
      drain();

      // Reset while the GAP=2 build sits in its gap.
      kick(2);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (2) step();

      // Reset overrides a simultaneous start.
      rst   = 1'b1;
      start = 1'b1;
      count = 8'd3;
      step();
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) step();

      // Abort while idle does nothing.
      abort = 1'b1;
      repeat (3) step();
      abort = 1'b0;

      // Random short transfers, with an occasional abort.
      for (int k = 0; k < 4; k++) begin
         kick(int'($urandom_range(1, 4)));
         repeat ($urandom_range(0, 6)) step();
         abort = ($urandom_range(0, 1) == 1);
         step();
         abort = 1'b0;
         drain();
      end

      // Maximum repeat count must not wrap.
      kick(255);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
